// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R/I-type RV32I core.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_COUNT_EN.
module instr_sequencer #(
  parameter int              ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int              FETCH_TIMEOUT = 16,
  parameter int              OPCODE        = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  input  logic              reg_write_i,
  output logic              alu_en_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              retire_o,
  output logic              halted_o,
  output logic [1:0]        trap_cause_o,
  output logic [2:0]        state_o,
  output logic [31:0]       instret_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [7:0]        TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);
  localparam logic [OPCODE-1:0] OP_REG       = OPCODE'(7'b0110011);
  localparam logic [OPCODE-1:0] OP_IMM       = OPCODE'(7'b0010011);
  localparam logic [1:0]        CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0]        CAUSE_TIMEOUT = 2'd2;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [31:0]         ir_r;
  logic [7:0]          cnt_r;
  logic                halted_r;
  logic [1:0]          cause_r;
  logic                legal_s;
  logic                timeout_s;

  assign legal_s   = (ir_r[OPCODE-1:0] == OP_REG) || (ir_r[OPCODE-1:0] == OP_IMM);
  assign timeout_s = (cnt_r == TIMEOUT_LAST);

  // Next-state logic; an ack in the timeout cycle takes priority over the trap.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (run_i) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ack_i)     state_s = S_DECODE;
        else if (timeout_s) state_s = S_TRAP;
        else                state_s = S_FETCH;
      end
      S_DECODE: begin
        if (legal_s) state_s = S_EXECUTE;
        else         state_s = S_TRAP;
      end
      S_EXECUTE: state_s = S_WRITEBACK;
      S_WRITEBACK: begin
        if (run_i) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_TRAP:  state_s = S_TRAP;
      default: state_s = S_TRAP;
    endcase
  end

  // State, PC, IR, fetch-timeout counter and trap bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= 32'd0;
      cnt_r    <= 8'd0;
      halted_r <= 1'b0;
      cause_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        S_FETCH: begin
          if (imem_ack_i) begin
            ir_r  <= imem_rdata_i;
            cnt_r <= 8'd0;
          end else if (timeout_s) begin
            cnt_r    <= 8'd0;
            halted_r <= 1'b1;
            cause_r  <= CAUSE_TIMEOUT;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_DECODE: begin
          if (!legal_s) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_ILLEGAL;
          end
        end
        S_WRITEBACK: pc_r <= pc_r + ADDR_W'(4);
        default: ;
      endcase
    end
  end

  assign imem_req_o   = (state_r == S_FETCH);
  assign imem_addr_o  = pc_r;
  assign alu_en_o     = (state_r == S_EXECUTE);
  assign retire_o     = (state_r == S_WRITEBACK);
  assign rf_we_o      = (state_r == S_WRITEBACK) && reg_write_i && (ir_r[11:7] != 5'd0);
  assign instr_o      = ir_r;
  assign pc_o         = pc_r;
  assign halted_o     = halted_r;
  assign trap_cause_o = cause_r;
  assign state_o      = state_r;

`ifdef SEQ_INSTRET_COUNT_EN
  logic [31:0] instret_r;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= 32'd0;
    end else if (state_r == S_WRITEBACK) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret_o = instret_r;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected retire/trap events,
// a monitor pops and compares them whenever the DUT retires or halts.
module tb_instr_sequencer;

  localparam logic [31:0] RPC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, run, ack, reg_write;
  logic [31:0] rdata;
  logic        imem_req, alu_en, rf_we, retire, halted;
  logic [31:0] imem_addr, instr, pc, instret;
  logic [1:0]  cause;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          is_trap;
    logic [31:0] instr;
    logic [31:0] pc;
    bit          rf_we;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  instr_sequencer #(.ADDR_W(32), .RESET_PC(RPC), .FETCH_TIMEOUT(16), .OPCODE(7)) dut (
    .clk(clk), .reset(reset), .run_i(run),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .instr_o(instr), .reg_write_i(reg_write), .alu_en_o(alu_en), .rf_we_o(rf_we),
    .pc_o(pc), .retire_o(retire), .halted_o(halted), .trap_cause_o(cause),
    .state_o(state), .instret_o(instret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compares DUT retire / trap events against the scoreboard.
  logic halted_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (retire === 1'b1) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("retire_kind", {31'd0, e.is_trap}, 32'd0);
        chk("retire_instr", instr, e.instr);
        chk("retire_pc", pc, e.pc);
        chk("retire_rf_we", {31'd0, rf_we}, {31'd0, e.rf_we});
        chk("retire_cycle", cyc, e.cyc);
      end
    end
    if (halted === 1'b1 && halted_prev === 1'b0) begin
      if (sb.size() == 0) begin
        chk("trap_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("trap_kind", {31'd0, e.is_trap}, 32'd1);
        chk("trap_cause", {30'd0, cause}, {30'd0, e.cause});
        chk("trap_pc", pc, e.pc);
      end
    end
    halted_prev = halted;
  end

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; ack = 1'b0; reg_write = 1'b0; rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  // Serve one fetch after `waits` wait cycles and queue the expected retire.
  task automatic fetch(input logic [31:0] ins, input int waits, input logic rw,
                       input logic [31:0] exp_pc, input bit exp_we);
    exp_t e;
    int c0;
    wait_req();
    c0 = cyc;
    for (int i = 0; i < waits; i++) begin
      chk("req_stable", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, exp_pc);
      @(negedge clk);
    end
    chk("req_at_ack", {31'd0, imem_req}, 32'd1);
    chk("addr_at_ack", imem_addr, exp_pc);
    e.is_trap = 1'b0; e.instr = ins; e.pc = exp_pc; e.rf_we = exp_we;
    e.cause = 2'd0; e.cyc = c0 + waits + 3;
    sb.push_back(e);
    ack = 1'b1; rdata = ins; reg_write = rw;
    @(negedge clk);
    ack = 1'b0; rdata = 32'hDEAD_BEEF;
  endtask

  task automatic push_trap(input logic [1:0] c, input logic [31:0] p);
    exp_t e;
    e.is_trap = 1'b1; e.instr = 32'd0; e.pc = p; e.rf_we = 1'b0; e.cause = c; e.cyc = 0;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] exp_instret(input int n);
`ifdef SEQ_INSTRET_COUNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    int n;
    do_reset();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_ir", instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_strobes", {28'd0, imem_req, alu_en, rf_we, retire}, 32'd0);
    chk("rst_instret", instret, 32'd0);

    // addi x1,x0,5 zero-wait, PC wraps to 0; then add x3,x1,x2 with two waits back-to-back
    run = 1'b1;
    fetch(32'h0050_0093, 0, 1'b1, RPC, 1'b1);
    fetch(32'h0020_81B3, 2, 1'b1, 32'd0, 1'b1);
    // addi x0,x0,0 with reg_write: write suppressed; drop run during EXECUTE
    fetch(32'h0000_0013, 0, 1'b1, 32'd4, 1'b0);
    @(negedge clk);
    chk("exec_alu_en", {31'd0, alu_en}, 32'd1);
    chk("exec_state", {29'd0, state}, 32'd3);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_drop", {29'd0, state}, 32'd0);
    chk("pc_after_three", pc, 32'd8);
    chk("instret_three", instret, exp_instret(3));
    for (int i = 0; i < 4; i++) begin
      chk("no_req_idle", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end

    // load opcode traps with cause 1, PC held
    run = 1'b1;
    push_trap(2'd1, 32'd8);
    wait_req();
    ack = 1'b1; rdata = 32'h0000_2003;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("illegal_state", {29'd0, state}, 32'd5);
    ack = 1'b1; rdata = 32'h0050_0093;
    repeat (4) @(negedge clk);
    ack = 1'b0;
    chk("trap_sticky_state", {29'd0, state}, 32'd5);
    chk("trap_sticky_halted", {31'd0, halted}, 32'd1);
    chk("trap_sticky_cause", {30'd0, cause}, 32'd1);
    chk("trap_sticky_pc", pc, 32'd8);
    chk("trap_ir_held", instr, 32'h0000_2003);
    chk("trap_strobes", {28'd0, imem_req, alu_en, rf_we, retire}, 32'd0);

    do_reset();
    chk("rst2_state", {29'd0, state}, 32'd0);
    chk("rst2_pc", pc, RPC);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_cause", {30'd0, cause}, 32'd0);

    // no ack: 16 FETCH cycles then timeout trap
    run = 1'b1;
    push_trap(2'd2, RPC);
    wait_req();
    n = 0;
    while (state === 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    chk("timeout_fetch_cycles", 32'(n), 32'd16);
    chk("timeout_state", {29'd0, state}, 32'd5);

    // ack on the 16th FETCH cycle wins over the timeout
    do_reset();
    run = 1'b1;
    fetch(32'h0050_0093, 15, 1'b1, RPC, 1'b1);
    run = 1'b0;
    chk("late_ack_decode", {29'd0, state}, 32'd2);
    repeat (3) @(negedge clk);
    chk("late_ack_idle", {29'd0, state}, 32'd0);
    chk("late_ack_halted", {31'd0, halted}, 32'd0);
    chk("late_ack_pc_wrap", pc, 32'd0);
    chk("late_ack_instret", instret, exp_instret(1));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
